// File: rtl/mxv_pkg.sv
// Shared types and defaults for the MxV datapath.
//   rowState_t : row/column stage sequencing states
//   accWidth() : accumulator width wide enough for a full-length dot product
package mxv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        POP,
        WAIT,
        DONE
    } rowState_t;

    localparam int unsigned DEF_DATA_WIDTH = 4;
    localparam int unsigned DEF_DIM        = 4;
    localparam int unsigned DEF_IDX_WIDTH  = 2;
    localparam int unsigned DEF_POP_GAP    = 3;

    // Sum of 2**idxWidth products of two dataWidth-bit operands never overflows this.
    function automatic int unsigned accWidth(input int unsigned dataWidth,
                                             input int unsigned idxWidth);
        return 2 * dataWidth + idxWidth;
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Registered unsigned multiply-accumulate.
//   clk, reset : clock, async active-high reset
//   clear      : synchronous clear of the accumulator (wins over enable)
//   enable     : acc <= acc + a*b on this edge
//   a, b       : unsigned operands
//   acc        : accumulator value
module mac_unit #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned ACC_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc
);

    localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

    logic [PROD_WIDTH-1:0] product;

    // Operands widened first so the product keeps all its bits.
    assign product = PROD_WIDTH'(a) * PROD_WIDTH'(b);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc + ACC_WIDTH'(product);
        end
    end

endmodule

// File: rtl/row_dot_product.sv
// Drains one matrix row (DIM elements) from the row FIFO and returns its dot
// product with a locally held vector.
//   clk, reset            : clock, async active-high reset
//   start                 : begin a row (sampled in IDLE only)
//   vec_load/idx/data     : vector file write port (ignored while busy)
//   fifo_data, fifo_empty : FIFO head element and empty flag
//   fifo_pop              : one-cycle pop request
//   result, result_valid  : last dot product and its one-cycle update strobe
//   busy                  : high whenever not IDLE
module row_dot_product
    import mxv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DIM        = DEF_DIM,
    parameter int unsigned IDX_WIDTH  = DEF_IDX_WIDTH,
    parameter int unsigned ACC_WIDTH  = accWidth(DATA_WIDTH, IDX_WIDTH),
    parameter int unsigned POP_GAP    = DEF_POP_GAP
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  vec_load,
    input  logic [IDX_WIDTH-1:0]  vec_idx,
    input  logic [DATA_WIDTH-1:0] vec_data,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_pop,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  result_valid,
    output logic                  busy
);

    localparam int unsigned          GAP_WIDTH = (POP_GAP > 2) ? $clog2(POP_GAP) : 1;
    localparam logic [GAP_WIDTH-1:0] GAP_LAST  = GAP_WIDTH'(POP_GAP - 2);
    localparam logic [IDX_WIDTH-1:0] IDX_LAST  = IDX_WIDTH'(DIM - 1);

    rowState_t             state;
    rowState_t             stateNext;
    logic [IDX_WIDTH-1:0]  index;
    logic [GAP_WIDTH-1:0]  gapCnt;
    logic [DATA_WIDTH-1:0] vecMem [DIM];
    logic [ACC_WIDTH-1:0]  accValue;

    logic popNext;
    logic validNext;
    logic accClear;
    logic accEnable;
    logic idxClear;
    logic idxInc;
    logic gapClear;
    logic gapInc;

    // Vector file: writable only while idle, out-of-range indices dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DIM); i++) begin
                vecMem[i] <= '0;
            end
        end else if (vec_load && !busy && (32'(vec_idx) < DIM)) begin
            vecMem[vec_idx] <= vec_data;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and control decode.
    always_comb begin
        stateNext = state;
        popNext   = 1'b0;
        validNext = 1'b0;
        accClear  = 1'b0;
        accEnable = 1'b0;
        idxClear  = 1'b0;
        idxInc    = 1'b0;
        gapClear  = 1'b0;
        gapInc    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accClear  = 1'b1;
                    idxClear  = 1'b1;
                    stateNext = CHECK;
                end
            end
            CHECK: begin
                // Pop is registered, so it is raised for exactly the POP cycle.
                if (!fifo_empty) begin
                    popNext   = 1'b1;
                    stateNext = POP;
                end
            end
            POP: begin
                accEnable = 1'b1;
                gapClear  = 1'b1;
                stateNext = WAIT;
            end
            WAIT: begin
                if (gapCnt == GAP_LAST) begin
                    if (index == IDX_LAST) begin
                        validNext = 1'b1;
                        stateNext = DONE;
                    end else begin
                        idxInc    = 1'b1;
                        stateNext = CHECK;
                    end
                end else begin
                    gapInc = 1'b1;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Row index and post-pop gap counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index  <= '0;
            gapCnt <= '0;
        end else begin
            if (idxClear) begin
                index <= '0;
            end else if (idxInc) begin
                index <= index + IDX_WIDTH'(1);
            end
            if (gapClear) begin
                gapCnt <= '0;
            end else if (gapInc) begin
                gapCnt <= gapCnt + GAP_WIDTH'(1);
            end
        end
    end

    // Registered outputs; result is captured as DONE is entered so it lines up
    // with result_valid (the last MAC landed at least two cycles earlier).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_pop     <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
        end else begin
            fifo_pop     <= popNext;
            result_valid <= validNext;
            busy         <= (stateNext != IDLE);
            if (validNext) begin
                result <= accValue;
            end
        end
    end

    mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .clear  (accClear),
        .enable (accEnable),
        .a      (fifo_data),
        .b      (vecMem[index]),
        .acc    (accValue)
    );

endmodule
